// File: rtl/dsp_capture_monitor.sv
// Capture monitor beside the DSP: snapshots the stereo DAC output and packed voice
// state on each rising edge of idle into a first-word fall-through FIFO.
module dsp_capture_monitor #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_VOICES = 8,
  parameter int STATE_W    = 4,
  parameter int DEPTH      = 64
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          idle,
  input  logic signed [SAMPLE_W-1:0]                    dac_out_l,
  input  logic signed [SAMPLE_W-1:0]                    dac_out_r,
  input  logic [NUM_VOICES*STATE_W-1:0]                 voice_states,
  input  logic [1:0]                                    mode,
  input  logic                                          arm,
  input  logic                                          disarm,
  input  logic                                          rd_en,
  output logic                                          rd_valid,
  output logic [2*SAMPLE_W+NUM_VOICES*STATE_W-1:0]      rd_data,
  output logic [$clog2(DEPTH+1)-1:0]                    count,
  output logic                                          overflow,
  output logic                                          triggered,
  output logic                                          done
);

  localparam int DW = 2*SAMPLE_W + NUM_VOICES*STATE_W;
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {OFF, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t          state_reg;
  logic            oneshot_reg;
  logic            idle_q;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            overflow_reg;
  logic            triggered_reg;
  logic            done_reg;
  logic [DW-1:0]   mem [DEPTH];

  logic cap_event;
  logic push_req;
  logic trig_hit;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign cap_event = idle & ~idle_q;
  assign full      = (count_reg == FULL_CNT);
  // arm flushes the FIFO in the same cycle, so any pop request is moot then
  assign pop       = rd_en && (count_reg != '0) && !arm;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    push_req = 1'b0;
    trig_hit = 1'b0;
    if (cap_event && !arm && !disarm) begin
      case (state_reg)
        WAIT_TRIG: begin
          if (dac_out_l != '0 || dac_out_r != '0) begin
            push_req = 1'b1;
            trig_hit = 1'b1;
          end
        end
        CAPTURE: push_req = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (!push && pop)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= OFF;
      oneshot_reg   <= 1'b0;
      idle_q        <= 1'b1;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      triggered_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      idle_q <= idle;
      if (arm) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        count_reg     <= '0;
        overflow_reg  <= 1'b0;
        triggered_reg <= 1'b0;
        done_reg      <= 1'b0;
        oneshot_reg   <= (mode == 2'd1);
        state_reg     <= (mode == 2'd2) ? WAIT_TRIG : CAPTURE;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_next;
        if (drop) overflow_reg <= 1'b1;
        // the trigger sample itself is the first entry of a one-shot capture
        if (trig_hit) begin
          triggered_reg <= 1'b1;
          oneshot_reg   <= 1'b1;
          state_reg     <= CAPTURE;
        end
        if (disarm) begin
          state_reg <= OFF;
          done_reg  <= 1'b0;
        end else if (state_reg == CAPTURE && oneshot_reg && push && count_next == FULL_CNT) begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr_reg] <= {voice_states, dac_out_l, dac_out_r};
  end

  assign rd_valid  = (count_reg != '0);
  assign rd_data   = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign triggered = triggered_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_dsp_capture_monitor.sv
// Bench for dsp_capture_monitor: directed scenarios plus random traffic, all
// compared each cycle against a queue-based behavioural model.
module tb_dsp_capture_monitor;

  localparam int SW = 16;
  localparam int NV = 8;
  localparam int ST = 4;
  localparam int D  = 4;
  localparam int DW = 2*SW + NV*ST;
  localparam int CW = $clog2(D+1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              idle = 1'b1;
  logic [SW-1:0]     dac_out_l = '0;
  logic [SW-1:0]     dac_out_r = '0;
  logic [NV*ST-1:0]  voice_states = '0;
  logic [1:0]        mode = 2'd0;
  logic              arm = 1'b0;
  logic              disarm = 1'b0;
  logic              rd_en = 1'b0;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              triggered;
  logic              done;

  dsp_capture_monitor #(.SAMPLE_W(SW), .NUM_VOICES(NV), .STATE_W(ST), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .idle(idle),
    .dac_out_l(dac_out_l), .dac_out_r(dac_out_r), .voice_states(voice_states),
    .mode(mode), .arm(arm), .disarm(disarm), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .overflow(overflow), .triggered(triggered), .done(done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // behavioural model
  logic [DW-1:0] q[$];
  bit m_prev_idle, m_running, m_waiting, m_single, m_finished, m_ovf, m_trig;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev_idle = 1'b1;
    m_running = 0; m_waiting = 0; m_single = 0; m_finished = 0; m_ovf = 0; m_trig = 0;
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".valid"}, 64'(rd_valid), 64'(q.size() > 0));
    chk({tag, ".data"}, 64'(rd_data), 64'(head));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".trig"}, 64'(triggered), 64'(m_trig));
    chk({tag, ".done"}, 64'(done), 64'(m_finished));
  endtask

  // one clock: drive inputs, advance the model, then compare after the edge
  task automatic cyc(input bit i, input logic [SW-1:0] li, input logic [SW-1:0] ri,
                     input logic [NV*ST-1:0] vsi, input bit a, input bit d, input bit rd,
                     input logic [1:0] m);
    bit ev, want, popped, pushed;
    idle = i; dac_out_l = li; dac_out_r = ri; voice_states = vsi;
    arm = a; disarm = d; rd_en = rd; mode = m;
    ev = i && !m_prev_idle;
    m_prev_idle = i;
    if (a) begin
      q.delete();
      m_ovf = 0; m_trig = 0; m_finished = 0;
      m_waiting = (m == 2'd2);
      m_running = (m != 2'd2);
      m_single  = (m == 2'd1);
    end else begin
      want = ev && !d && (m_running || (m_waiting && (li != 0 || ri != 0)));
      popped = rd && q.size() > 0;
      pushed = 0;
      if (popped) void'(q.pop_front());
      if (want) begin
        if (q.size() < D) begin
          q.push_back({vsi, li, ri});
          pushed = 1;
        end else m_ovf = 1;
      end
      if (m_waiting && want) begin
        m_trig = 1; m_waiting = 0; m_running = 1; m_single = 1;
      end else if (m_running && m_single && pushed && q.size() == D) begin
        m_running = 0; m_finished = 1;
      end
      if (d) begin
        m_running = 0; m_waiting = 0; m_finished = 0;
      end
    end
    @(posedge clock);
    #1;
    check_all("cyc");
  endtask

  task automatic ev(input logic [SW-1:0] li, input logic [SW-1:0] ri, input logic [NV*ST-1:0] vsi,
                    input bit rd);
    cyc(1'b0, '0, '0, '0, 0, 0, 0, 2'd0);
    cyc(1'b1, li, ri, vsi, 0, 0, rd, 2'd0);
  endtask

  task automatic do_arm(input logic [1:0] m);
    cyc(idle, '0, '0, '0, 1, 0, 0, m);
  endtask

  task automatic pop_one();
    cyc(1'b0, '0, '0, '0, 0, 0, 1, 2'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // idle high out of reset must not count as an event
    for (int k = 0; k < 3; k++) cyc(1'b1, 16'h1, 16'h1, '0, 0, 0, 0, 2'd0);
    chk("no_entry_after_reset", 64'(count), 64'd0);
    do_arm(2'd0);
    ev(16'h1234, 16'hFEDC, 32'h0000_00A5, 0);
    chk("first_data", 64'(rd_data), 64'h0000_00A5_1234_FEDC);
    chk("first_count", 64'(count), 64'd1);
    $display("scenario first-capture: count=%0d data=%h", count, rd_data);

    // one-shot fills and stops
    do_arm(2'd1);
    for (int k = 1; k <= 6; k++) begin
      ev(SW'(k), 16'h0, '0, 0);
      if (k == 4) chk("oneshot_done_at4", 64'(done), 64'd1);
    end
    for (int k = 1; k <= 4; k++) begin
      chk("oneshot_head", 64'(rd_data[31:16]), 64'(k));
      pop_one();
    end
    chk("oneshot_empty", 64'(rd_valid), 64'd0);
    chk("oneshot_no_ovf", 64'(overflow), 64'd0);
    $display("scenario one-shot: done=%0d ovf=%0d", done, overflow);

    // continuous overflow, then push while full with pop
    do_arm(2'd0);
    for (int k = 1; k <= 5; k++) ev(SW'(k), 16'h0, '0, 0);
    chk("cont_ovf", 64'(overflow), 64'd1);
    chk("cont_count", 64'(count), 64'd4);
    ev(16'd5, 16'h0, '0, 1);
    chk("full_pushpop_count", 64'(count), 64'd4);
    for (int k = 2; k <= 5; k++) begin
      chk("cont_head", 64'(rd_data[31:16]), 64'(k));
      pop_one();
    end
    $display("scenario continuous: ovf=%0d count=%0d", overflow, count);

    // trigger mode
    do_arm(2'd2);
    ev(16'd0, 16'd0, '0, 0);
    ev(16'd0, 16'd0, '0, 0);
    chk("trig_not_yet", 64'(triggered), 64'd0);
    ev(16'd0, 16'd7, '0, 0);
    ev(16'd3, 16'd0, '0, 0);
    chk("trig_set", 64'(triggered), 64'd1);
    chk("trig_count", 64'(count), 64'd2);
    chk("trig_head", 64'(rd_data[31:0]), 64'h0000_0007);
    $display("scenario trigger: triggered=%0d count=%0d", triggered, count);

    // events coincident with arm / disarm
    do_arm(2'd0);
    ev(16'h11, 16'h0, '0, 0);
    cyc(1'b0, '0, '0, '0, 0, 0, 0, 2'd0);
    cyc(1'b1, 16'h99, 16'h0, '0, 1, 0, 0, 2'd0);
    chk("arm_event_dropped", 64'(count), 64'd0);
    ev(16'h22, 16'h0, '0, 0);
    ev(16'h33, 16'h0, '0, 0);
    cyc(1'b0, '0, '0, '0, 0, 0, 0, 2'd0);
    cyc(1'b1, 16'h44, 16'h0, '0, 0, 1, 0, 2'd0);
    chk("disarm_keeps", 64'(count), 64'd2);
    ev(16'h55, 16'h0, '0, 0);
    chk("off_ignores", 64'(count), 64'd2);
    do_arm(2'd0);
    chk("rearm_flush", 64'(count), 64'd0);
    // empty FIFO: push with rd_en ignores the pop
    ev(16'h66, 16'h0, '0, 1);
    chk("empty_pushpop", 64'(count), 64'd1);
    $display("scenario arm/disarm: count=%0d", count);

    // asynchronous reset mid-capture
    ev(16'h1, 16'h0, '0, 0);
    ev(16'h2, 16'h0, '0, 0);
    chk("pre_reset_count", 64'(count), 64'd3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    ev(16'h7, 16'h7, '0, 0);
    ev(16'h8, 16'h8, '0, 0);
    chk("post_reset_ignored", 64'(count), 64'd0);
    $display("scenario async-reset: count=%0d", count);

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit a, d, rd, i;
      logic [SW-1:0] li, ri;
      i  = 1'($urandom_range(0, 1));
      li = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
      ri = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
      a  = ($urandom_range(0, 39) == 0);
      d  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 9) < 3);
      cyc(i, li, ri, NV*ST'($urandom), a, d, rd, 2'($urandom_range(0, 3)));
    end
    $display("scenario random: 800 cycles, total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
